ex_mc_seq: RTL and testbench

- Sequencer for multi-cycle EX-stage units (carry-less multiplier, iterative divider, future additions).
- Sits beside the EX ALU. Accepts one multi-cycle request at a time from EX decode and issues a one-cycle start to the selected unit.
- Holds the pipeline via stall_req until the result is captured, honours external stall and flush, and traps on unit timeout.

---
 rtl/ex_mc_seq.sv | 166 ++++++++++++++++
 tb/tb_ex_mc_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mc_seq.sv
// Sequencer for multi-cycle EX-stage units: issues a one-cycle start to the
// selected unit, holds the pipeline until the result is captured, traps on timeout.
module ex_mc_seq #(
  parameter int N_UNITS = 2,
  parameter int TIMEOUT = 64,
  parameter int W       = 32,
  localparam int SW     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ext_stall,
  input  logic                 flush,
  input  logic                 req_valid,
  input  logic [SW-1:0]        req_sel,
  input  logic [N_UNITS-1:0]   eoc,
  input  logic [N_UNITS*W-1:0] unit_res,
  output logic [N_UNITS-1:0]   start,
  output logic [N_UNITS-1:0]   abort,
  output logic                 unit_stall,
  output logic                 stall_req,
  output logic [W-1:0]         res,
  output logic                 res_valid,
  output logic                 trap,
  output logic [31:0]          busy_cycles,
  output logic [1:0]           dbg_state
);

  // Handshake: EX decode holds req_valid/req_sel stable while stall_req is high;
  // stall_req falls in DONE (res/res_valid/trap are then valid) and the request
  // is consumed on the first DONE cycle without ext_stall.

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [31:0]   BUSY_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        res_q, res_d;
  logic                trap_q, trap_d;
  logic [31:0]         busy_q, busy_d;
  logic [N_UNITS-1:0]  start_q, start_d;
  logic [N_UNITS-1:0]  abort_q, abort_d;

  logic                eoc_sel;
  logic [W-1:0]        res_sel;

  function automatic logic [N_UNITS-1:0] onehot(input logic [SW-1:0] idx);
    logic [N_UNITS-1:0] v;
    v = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (idx == SW'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

  // Only the latched unit's eoc/result are observed; other units are ignored.
  always_comb begin
    eoc_sel = 1'b0;
    res_sel = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (sel_q == SW'(k)) begin
        eoc_sel = eoc[k];
        res_sel = unit_res[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    trap_d  = trap_q;
    busy_d  = busy_q;
    start_d = '0;
    abort_d = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !ext_stall && !flush) begin
          state_d = S_ISSUE;
          sel_d   = req_sel;
          cnt_d   = '0;
          start_d = onehot(req_sel);
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
          abort_d = onehot(sel_q);
        end else begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!ext_stall) begin
          cnt_d = cnt_q + CNT_ONE;
          if (busy_q != BUSY_MAX) busy_d = busy_q + 32'd1;
        end
        // flush wins over completion and timeout in the same cycle
        if (flush) begin
          state_d = S_IDLE;
          abort_d = onehot(sel_q);
        end else if (eoc_sel) begin
          state_d = S_DONE;
          res_d   = res_sel;
          trap_d  = 1'b0;
        end else if (!ext_stall && (cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
          res_d   = '0;
          trap_d  = 1'b1;
          abort_d = onehot(sel_q);
        end
      end
      S_DONE: begin
        if (flush || !ext_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      trap_q  <= 1'b0;
      busy_q  <= '0;
      start_q <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      trap_q  <= trap_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  assign start       = start_q;
  assign abort       = abort_q;
  assign unit_stall  = ext_stall;
  assign stall_req   = req_valid && !flush && (state_q != S_DONE);
  assign res         = res_q;
  assign res_valid   = (state_q == S_DONE);
  assign trap        = trap_q;
  assign busy_cycles = busy_q;
  assign dbg_state   = state_q;

  a_start_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(start_q));
  a_abort_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(abort_q));
  a_start_abort_excl: assert property (@(posedge clk) disable iff (!reset_n) !((|start_q) && (|abort_q)));

endmodule

// File: tb/tb_ex_mc_seq.sv
// Randomized bench for ex_mc_seq: outcome model per operation, scoreboard queues
// filled at issue time and drained by a negedge monitor.
module tb_ex_mc_seq;

  localparam int N   = 2;
  localparam int TMO = 64;
  localparam int W   = 32;

  localparam int K_RES   = 0;
  localparam int K_TMO   = 1;
  localparam int K_FLUSH = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           ext_stall, flush, req_valid;
  logic [0:0]     req_sel;
  logic [N-1:0]   eoc;
  logic [N*W-1:0] unit_res;
  logic [N-1:0]   start, abort;
  logic           unit_stall, stall_req, res_valid, trap;
  logic [W-1:0]   res;
  logic [31:0]    busy_cycles;
  logic [1:0]     dbg_state;

  ex_mc_seq #(.N_UNITS(N), .TIMEOUT(TMO), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .ext_stall(ext_stall), .flush(flush),
    .req_valid(req_valid), .req_sel(req_sel), .eoc(eoc), .unit_res(unit_res),
    .start(start), .abort(abort), .unit_stall(unit_stall), .stall_req(stall_req),
    .res(res), .res_valid(res_valid), .trap(trap), .busy_cycles(busy_cycles),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   kind;
    logic [0:0]   sel;
    logic [W-1:0] res;
    logic         trap;
    logic [31:0]  busy;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] exp_start_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] model_res;
  logic         model_trap;
  logic [31:0]  model_busy;
  logic         exp_sr, exp_rv;
  logic         mon_en  = 1'b0;
  logic         prev_rv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] oh(input int s);
    logic [N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic rand_res();
    for (int k = 0; k < N; k++) unit_res[k*W +: W] = $urandom;
  endtask

  // Outcome of one operation from its BUSY-cycle timeline: flush beats eoc,
  // eoc beats timeout, timeout on the TMO-th unstalled BUSY cycle.
  task automatic model_op(input int eoc_at, input int st_s, input int st_l, input int flush_at,
                          output int kind, output int j_end, output int inc);
    logic stl;
    inc = 0; kind = K_TMO; j_end = 0;
    for (int j = 0; j < 10000; j++) begin
      stl = (j >= st_s) && (j < st_s + st_l);
      if (!stl) inc++;
      if (j == flush_at) begin kind = K_FLUSH; j_end = j; return; end
      if (j == eoc_at) begin kind = K_RES; j_end = j; return; end
      if (!stl && inc == TMO) begin kind = K_TMO; j_end = j; return; end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents start, a new result or an abort.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (start != '0) begin
        check("start_abort_excl", 64'((|start) && (|abort)), 64'd0);
        if (exp_start_q.size() == 0) check("unexpected_start", 64'(start), 64'd0);
        else check("start", 64'(start), 64'(exp_start_q.pop_front()));
      end
      if (res_valid && !prev_rv) begin
        if (exp_q.size() == 0) check("unexpected_res_valid", 64'(res_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("done_expected", 64'(res_valid), 64'(e.kind != 2'(K_FLUSH)));
          if (e.kind != 2'(K_FLUSH)) begin
            model_res  = e.res;
            model_trap = e.trap;
            check("done_abort", 64'(abort), (e.kind == 2'(K_TMO)) ? 64'(oh(int'(e.sel))) : 64'd0);
            check("done_busy_cycles", 64'(busy_cycles), 64'(e.busy));
          end
        end
      end else if (abort != '0) begin
        if (exp_q.size() == 0) check("unexpected_abort", 64'(abort), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("flush_abort", 64'(abort), (e.kind == 2'(K_FLUSH)) ? 64'(oh(int'(e.sel))) : 64'd0);
          check("flush_busy_cycles", 64'(busy_cycles), 64'(e.busy));
        end
      end
      check("res", 64'(res), 64'(model_res));
      check("trap", 64'(trap), 64'(model_trap));
      check("res_valid", 64'(res_valid), 64'(exp_rv));
      check("stall_req", 64'(stall_req), 64'(exp_sr));
      check("unit_stall", 64'(unit_stall), 64'(ext_stall));
      prev_rv = res_valid;
    end
  end

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_sel   = 1'($urandom_range(0, 1));
      flush     = 1'b0;
      ext_stall = 1'b0;
      if (req_valid) begin
        if ($urandom_range(0, 1) == 1) flush = 1'b1;
        else ext_stall = 1'b1;
      end
      eoc = N'($urandom_range(0, 3));
      rand_res();
      exp_sr = req_valid && !flush;
      exp_rv = 1'b0;
    end
  endtask

  task automatic run_op(input int sel, input logic [W-1:0] data, input int eoc_at,
                        input int st_s, input int st_l, input int flush_at, input bit flush_issue,
                        input int done_stall, input bit done_flush);
    int   kind, j_end, inc;
    exp_t e;
    if (flush_issue) begin
      kind = K_FLUSH; j_end = 0; inc = 0;
    end else begin
      model_op(eoc_at, st_s, st_l, flush_at, kind, j_end, inc);
    end
    model_busy = model_busy + 32'(inc);
    e.kind = 2'(kind);
    e.sel  = 1'(sel);
    e.res  = (kind == K_RES) ? data : '0;
    e.trap = (kind == K_TMO);
    e.busy = model_busy;
    // request cycle
    @(posedge clk); #1;
    exp_start_q.push_back(oh(sel));
    exp_q.push_back(e);
    req_valid = 1'b1; req_sel = 1'(sel); ext_stall = 1'b0; flush = 1'b0;
    eoc = N'($urandom_range(0, 3)); rand_res();
    exp_sr = 1'b1; exp_rv = 1'b0;
    // issue cycle
    @(posedge clk); #1;
    ext_stall = 1'($urandom_range(0, 1)); flush = flush_issue; eoc = '0; rand_res();
    exp_sr = !flush_issue;
    if (!flush_issue) begin
      for (int j = 0; j <= j_end; j++) begin
        @(posedge clk); #1;
        req_sel   = 1'($urandom_range(0, 1));
        ext_stall = (j >= st_s) && (j < st_s + st_l);
        flush     = (j == flush_at);
        eoc       = N'($urandom_range(0, 3)) & ~oh(sel);
        rand_res();
        if (j == eoc_at) begin
          eoc = eoc | oh(sel);
          unit_res[sel*W +: W] = data;
        end
        exp_sr = !flush;
      end
    end
    if (kind == K_FLUSH) begin
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0; ext_stall = 1'b0; eoc = '0;
      exp_sr = 1'b0; exp_rv = 1'b0;
      return;
    end
    for (int d = 0; d <= done_stall; d++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      flush     = done_flush;
      ext_stall = done_flush ? 1'b1 : (d < done_stall);
      eoc       = N'($urandom_range(0, 3)); rand_res();
      exp_sr = 1'b0; exp_rv = 1'b1;
      if (done_flush) break;
    end
    req_valid = req_valid;
  endtask

  task automatic reset_mid_busy(input int sel, input int n_busy);
    @(posedge clk); #1;
    exp_start_q.push_back(oh(sel));
    req_valid = 1'b1; req_sel = 1'(sel); ext_stall = 1'b0; flush = 1'b0; eoc = '0;
    exp_sr = 1'b1; exp_rv = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < n_busy; j++) begin
      @(posedge clk); #1;
      eoc = N'($urandom_range(0, 3)) & ~oh(sel);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    req_valid = 1'b0; eoc = '0;
    model_res = '0; model_trap = 1'b0; model_busy = '0;
    exp_sr = 1'b0; exp_rv = 1'b0;
    #2;
    check("rst_start", 64'(start), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_busy_cycles", 64'(busy_cycles), 64'd0);
    check("rst_stall_req", 64'(stall_req), 64'd0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; ext_stall = 1'b0; flush = 1'b0; req_valid = 1'b0; req_sel = '0;
    eoc = '0; unit_res = '0;
    model_res = '0; model_trap = 1'b0; model_busy = '0; exp_sr = 1'b0; exp_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_start", 64'(start), 64'd0);
    check("init_abort", 64'(abort), 64'd0);
    check("init_res", 64'(res), 64'd0);
    check("init_res_valid", 64'(res_valid), 64'd0);
    check("init_trap", 64'(trap), 64'd0);
    check("init_busy_cycles", 64'(busy_cycles), 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    gap(2);
    // clean op, stalls in BUSY and DONE, timeouts, flush cases, wrong-unit eoc
    run_op(0, 32'hDEADBEEF, 0, 0, 0, -1, 1'b0, 0, 1'b0);
    gap(1);
    run_op(1, 32'h1234_5678, 14, 4, 5, -1, 1'b0, 3, 1'b0);
    gap(1);
    run_op(0, 32'h0, 100000, 0, 0, -1, 1'b0, 0, 1'b0);
    run_op(1, 32'h0, 100000, 10, 5, -1, 1'b0, 2, 1'b0);
    gap(2);
    run_op(0, 32'hCAFE_F00D, 1, 0, 0, 1, 1'b0, 0, 1'b0);
    run_op(0, 32'hA5A5_5A5A, 6, 0, 0, -1, 1'b0, 0, 1'b0);
    run_op(1, 32'h5555_AAAA, 3, 0, 0, -1, 1'b1, 0, 1'b0);
    run_op(1, 32'h0F0F_0F0F, 2, 1, 1, -1, 1'b0, 0, 1'b1);
    run_op(0, 32'h7777_0001, 63, 20, 3, -1, 1'b0, 1, 1'b0);
    gap(1);
    for (int i = 0; i < 30; i++) begin
      run_op($urandom_range(0, 1), $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 20),
             $urandom_range(0, 15),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6),
             ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1,
             ($urandom_range(0, 9) == 0),
             $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0));
      gap($urandom_range(0, 2));
    end
    reset_mid_busy(1, 3);
    gap(4);
    run_op(1, 32'hBEEF_0002, 2, 0, 0, -1, 1'b0, 0, 1'b0);
    gap(4);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("start_q_drained", 64'(exp_start_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
